// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding CPU data-bus to APB master with address decode and timeout.
module apb_master_bridge #(
  parameter int          NUM_SLAVES = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int          SLOT_LOG2  = 12,
  parameter int          TIMEOUT    = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     transfer,
  input  logic                     write,
  input  logic [31:0]              addr,
  input  logic [31:0]              wdata,
  input  logic [3:0]               strb,
  output logic [31:0]              rdata,
  output logic                     ready,
  output logic                     err,
  output logic [31:0]              PADDR,
  output logic [31:0]              PWDATA,
  output logic [3:0]               PSTRB,
  output logic                     PWRITE,
  output logic                     PENABLE,
  output logic [NUM_SLAVES-1:0]    PSEL,
  input  logic [32*NUM_SLAVES-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]    PREADY,
  input  logic [NUM_SLAVES-1:0]    PSLVERR
);
  localparam int SW = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1;
  localparam int CW = $clog2(TIMEOUT + 1) > 8 ? $clog2(TIMEOUT + 1) : 8;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t                state_q, state_d;
  logic [31:0]           paddr_q, paddr_d, pwdata_q, pwdata_d, rdata_q, rdata_d;
  logic [3:0]            pstrb_q, pstrb_d;
  logic                  pwrite_q, pwrite_d, penable_q, penable_d, miss_q, miss_d;
  logic                  ready_q, ready_d, err_q, err_d;
  logic [NUM_SLAVES-1:0] psel_q, psel_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [31:0]           off, sel_rdata;
  logic [SW-1:0]         slot;
  logic                  hit, capture, sel_ready, sel_err, expired;
  // Offset arithmetic avoids overflow when the window ends at the top of the address space.
  assign off       = addr - BASE_ADDR;
  assign hit       = (addr >= BASE_ADDR) && ((off >> SLOT_LOG2) < 32'(NUM_SLAVES));
  assign slot      = off[SLOT_LOG2 +: SW];
  assign capture   = transfer && !ready_q;
  assign sel_ready = |(PREADY & psel_q);
  assign sel_err   = |(PSLVERR & psel_q);
  assign expired   = cnt_q == CW'(TIMEOUT - 1);
  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      sel_rdata = sel_rdata | (psel_q[i] ? PRDATA[32*i +: 32] : 32'h0);
  end
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = capture ? SETUP : IDLE;
      SETUP:   state_d = miss_q ? IDLE : ACCESS;
      ACCESS:  state_d = (sel_ready || expired) ? IDLE : ACCESS;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    pwrite_d  = pwrite_q;
    penable_d = penable_q;
    psel_d    = psel_q;
    miss_d    = miss_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    ready_d   = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: if (capture) begin
        paddr_d  = addr;
        pwdata_d = wdata;
        pstrb_d  = write ? strb : 4'b0000;
        pwrite_d = write;
        miss_d   = !hit;
        psel_d   = hit ? NUM_SLAVES'(1) << slot : '0;
      end
      SETUP: begin
        penable_d = !miss_q;
        cnt_d     = '0;
        ready_d   = miss_q;
        err_d     = miss_q;
        rdata_d   = miss_q ? 32'h0 : rdata_q;
      end
      ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        if (sel_ready || expired) begin
          psel_d    = '0;
          penable_d = 1'b0;
          ready_d   = 1'b1;
          err_d     = sel_ready ? sel_err : 1'b1;
          rdata_d   = (sel_ready && !pwrite_q) ? sel_rdata : 32'h0;
        end
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      pwrite_q  <= 1'b0;
      penable_q <= 1'b0;
      psel_q    <= '0;
      miss_q    <= 1'b0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      pwrite_q  <= pwrite_d;
      penable_q <= penable_d;
      psel_q    <= psel_d;
      miss_q    <= miss_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
    end
  end
  assign rdata   = rdata_q;
  assign ready   = ready_q;
  assign err     = err_q;
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;
  assign PSTRB   = pstrb_q;
  assign PWRITE  = pwrite_q;
  assign PENABLE = penable_q;
  assign PSEL    = psel_q;
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: scenario tasks with a completion scoreboard for apb_master_bridge.
module tb_apb_master_bridge;
  logic         clk = 1'b0;
  logic         reset, transfer, write;
  logic [31:0]  addr, wdata, rdata, PADDR, PWDATA;
  logic [3:0]   strb, PSTRB, PSEL, PREADY, PSLVERR;
  logic         ready, err, PWRITE, PENABLE;
  logic [127:0] PRDATA;
  int vectors = 0;
  int miscompares = 0;
  typedef struct {logic [31:0] rdata; logic err;} exp_t;
  exp_t exp_q[$];

  apb_master_bridge #(.NUM_SLAVES(4), .BASE_ADDR(32'h1000_0000), .SLOT_LOG2(12), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .transfer(transfer), .write(write), .addr(addr), .wdata(wdata),
    .strb(strb), .rdata(rdata), .ready(ready), .err(err), .PADDR(PADDR), .PWDATA(PWDATA),
    .PSTRB(PSTRB), .PWRITE(PWRITE), .PENABLE(PENABLE), .PSEL(PSEL), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 clk = ~clk;

  // Every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (ready === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_ready: ready=1 with no outstanding request");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (rdata !== e.rdata || err !== e.err) begin
          miscompares++;
          $display("FAIL completion: got rdata=%h err=%b, expected rdata=%h err=%b", rdata, err, e.rdata, e.err);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    transfer = 1'b1; write = w; addr = a; wdata = d; strb = s;
  endtask

  task automatic test_reset();
    reset = 1'b1; PREADY = '0; PSLVERR = '0; PRDATA = '0;
    request(1'b1, 32'h1000_0000, 32'h5555_5555, 4'hF);
    tick(); tick();
    vectors++; if (PSEL !== 4'b0000 || PENABLE !== 1'b0 || ready !== 1'b0 || err !== 1'b0) begin miscompares++; $display("FAIL reset_ctl: PSEL=%b PENABLE=%b ready=%b err=%b, expected all 0", PSEL, PENABLE, ready, err); end
    vectors++; if (PADDR !== 32'h0 || PWDATA !== 32'h0 || PSTRB !== 4'h0 || PWRITE !== 1'b0 || rdata !== 32'h0) begin miscompares++; $display("FAIL reset_data: PADDR=%h PWDATA=%h PSTRB=%b PWRITE=%b rdata=%h, expected all 0", PADDR, PWDATA, PSTRB, PWRITE, rdata); end
    reset = 1'b0; transfer = 1'b0;
    tick();
    vectors++; if (PSEL !== 4'b0000) begin miscompares++; $display("FAIL reset_no_capture: PSEL=%b expected 0000", PSEL); end
  endtask

  task automatic test_write_zero_wait();
    PREADY = 4'b0100; PSLVERR = 4'b1011;
    request(1'b1, 32'h1000_2004, 32'h0000_AB00, 4'b0010);
    exp_q.push_back('{32'h0, 1'b0});
    tick();
    vectors++; if (PSEL !== 4'b0100 || PENABLE !== 1'b0) begin miscompares++; $display("FAIL wr_setup: PSEL=%b PENABLE=%b, expected 0100/0", PSEL, PENABLE); end
    vectors++; if (PADDR !== 32'h1000_2004 || PSTRB !== 4'b0010 || PWDATA !== 32'h0000_AB00 || PWRITE !== 1'b1) begin miscompares++; $display("FAIL wr_fields: PADDR=%h PSTRB=%b PWDATA=%h PWRITE=%b", PADDR, PSTRB, PWDATA, PWRITE); end
    addr = 32'hFFFF_FFF0; wdata = 32'h1234_5678; strb = 4'b1111;
    tick();
    vectors++; if (PSEL !== 4'b0100 || PENABLE !== 1'b1 || ready !== 1'b0) begin miscompares++; $display("FAIL wr_access: PSEL=%b PENABLE=%b ready=%b, expected 0100/1/0", PSEL, PENABLE, ready); end
    vectors++; if (PADDR !== 32'h1000_2004 || PWDATA !== 32'h0000_AB00) begin miscompares++; $display("FAIL wr_stable: PADDR=%h PWDATA=%h, expected captured values", PADDR, PWDATA); end
    tick();
    vectors++; if (ready !== 1'b1 || PSEL !== 4'b0000 || PENABLE !== 1'b0) begin miscompares++; $display("FAIL wr_done: ready=%b PSEL=%b PENABLE=%b, expected 1/0000/0", ready, PSEL, PENABLE); end
    transfer = 1'b0; PSLVERR = '0;
    tick();
    vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL wr_pulse: ready=%b expected 0", ready); end
  endtask

  task automatic test_read_wait();
    PREADY = 4'b1110; PRDATA = '0; PRDATA[31:0] = 32'hDEAD_BEEF; PRDATA[63:32] = 32'h0BAD_0BAD;
    request(1'b0, 32'h1000_0010, 32'hAAAA_AAAA, 4'b1111);
    exp_q.push_back('{32'hDEAD_BEEF, 1'b0});
    tick();
    vectors++; if (PSEL !== 4'b0001 || PSTRB !== 4'b0000 || PWRITE !== 1'b0) begin miscompares++; $display("FAIL rd_setup: PSEL=%b PSTRB=%b PWRITE=%b, expected 0001/0000/0", PSEL, PSTRB, PWRITE); end
    for (int c = 2; c <= 5; c++) begin
      tick();
      if (c == 5) PREADY = 4'b0001;
      vectors++; if (ready !== 1'b0 || PENABLE !== 1'b1) begin miscompares++; $display("FAIL rd_wait_c%0d: ready=%b PENABLE=%b, expected 0/1", c, ready, PENABLE); end
    end
    tick();
    vectors++; if (ready !== 1'b1 || rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL rd_done: ready=%b rdata=%h, expected 1/deadbeef", ready, rdata); end
    transfer = 1'b0; PREADY = '0;
    tick();
    vectors++; if (ready !== 1'b0 || rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL rd_hold: ready=%b rdata=%h, expected 0/deadbeef", ready, rdata); end
  endtask

  task automatic test_decode_miss();
    logic [31:0] miss_addr [3] = '{32'h2000_0000, 32'h1000_4000, 32'h0FFF_FFFC};
    PREADY = 4'b1111;
    foreach (miss_addr[k]) begin
      request(1'b0, miss_addr[k], 32'h0, 4'b0000);
      exp_q.push_back('{32'h0, 1'b1});
      tick();
      vectors++; if (PSEL !== 4'b0000) begin miscompares++; $display("FAIL miss_psel_%h: PSEL=%b expected 0000", miss_addr[k], PSEL); end
      tick();
      vectors++; if (ready !== 1'b1 || err !== 1'b1 || PSEL !== 4'b0000 || PENABLE !== 1'b0) begin miscompares++; $display("FAIL miss_done_%h: ready=%b err=%b PSEL=%b PENABLE=%b, expected 1/1/0000/0", miss_addr[k], ready, err, PSEL, PENABLE); end
      transfer = 1'b0;
      tick();
    end
  endtask

  task automatic test_timeout();
    PREADY = 4'b1101;
    request(1'b1, 32'h1000_1008, 32'hCAFE_F00D, 4'b1100);
    exp_q.push_back('{32'h0, 1'b1});
    tick();
    vectors++; if (PSEL !== 4'b0010) begin miscompares++; $display("FAIL to_setup: PSEL=%b expected 0010", PSEL); end
    for (int c = 2; c <= 5; c++) begin
      tick();
      vectors++; if (PSEL !== 4'b0010 || PENABLE !== 1'b1 || ready !== 1'b0) begin miscompares++; $display("FAIL to_access_c%0d: PSEL=%b PENABLE=%b ready=%b, expected 0010/1/0", c, PSEL, PENABLE, ready); end
    end
    tick();
    vectors++; if (ready !== 1'b1 || err !== 1'b1 || PSEL !== 4'b0000 || PENABLE !== 1'b0) begin miscompares++; $display("FAIL to_abort: ready=%b err=%b PSEL=%b PENABLE=%b, expected 1/1/0000/0", ready, err, PSEL, PENABLE); end
    tick();
    vectors++; if (PSEL !== 4'b0000 || ready !== 1'b0) begin miscompares++; $display("FAIL to_no_recapture: PSEL=%b ready=%b, expected 0000/0", PSEL, ready); end
    transfer = 1'b0; PREADY = '0;
    tick();
  endtask

  task automatic test_slave_error();
    PREADY = 4'b1000; PSLVERR = 4'b1001; PRDATA[127:96] = 32'h1234_5678;
    request(1'b0, 32'h1000_3FFC, 32'h0, 4'b0000);
    exp_q.push_back('{32'h1234_5678, 1'b1});
    tick();
    vectors++; if (PSEL !== 4'b1000) begin miscompares++; $display("FAIL se_setup: PSEL=%b expected 1000", PSEL); end
    tick(); tick();
    vectors++; if (ready !== 1'b1 || err !== 1'b1) begin miscompares++; $display("FAIL se_done: ready=%b err=%b, expected 1/1", ready, err); end
    transfer = 1'b0; PREADY = '0; PSLVERR = '0;
    tick();
  endtask

  task automatic test_reset_mid_transfer();
    request(1'b0, 32'h1000_0020, 32'h0, 4'b0000);
    tick(); tick();
    vectors++; if (PSEL !== 4'b0001 || PENABLE !== 1'b1) begin miscompares++; $display("FAIL rm_access: PSEL=%b PENABLE=%b, expected 0001/1", PSEL, PENABLE); end
    reset = 1'b1;
    tick();
    vectors++; if (PSEL !== 4'b0000 || PENABLE !== 1'b0 || ready !== 1'b0) begin miscompares++; $display("FAIL rm_abort: PSEL=%b PENABLE=%b ready=%b, expected 0000/0/0", PSEL, PENABLE, ready); end
    reset = 1'b0; transfer = 1'b0; PREADY = 4'b1111;
    tick(); tick();
    vectors++; if (ready !== 1'b0 || PSEL !== 4'b0000) begin miscompares++; $display("FAIL rm_idle: ready=%b PSEL=%b, expected 0/0000", ready, PSEL); end
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_decode_miss();
    test_timeout();
    test_slave_error();
    test_reset_mid_transfer();
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL scoreboard_drain: %0d completions missing, expected 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
